// File: rtl/strip_frame_tx.sv
// Serializes 104-bit strip frames into four contiguous 30-bit link words (header + 26-bit payload).
// Optional internal pattern generator enabled by defining STRIP_FRAME_TX_PATTERN_EN.
module strip_frame_tx #(
    parameter int unsigned IDLE_GAP  = 0,
    parameter logic [3:0]  IDLE_HDR  = 4'b0000,
    parameter logic [3:0]  FRAME_HDR = 4'b1010
) (
    input  logic         clk160,
    input  logic         reset_n,
`ifdef STRIP_FRAME_TX_PATTERN_EN
    input  logic         test_mode,
`endif
    input  logic [103:0] frame_data,
    input  logic         frame_valid,
    output logic         frame_ready,
    output logic [29:0]  strip_data_out,
    output logic         busy,
    output logic [15:0]  frame_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

    localparam logic [29:0] IDLE_WORD = {IDLE_HDR, 26'h0};
    localparam logic [3:0]  GAP_LAST  = 4'((IDLE_GAP > 0) ? IDLE_GAP - 1 : 0);

    if (IDLE_HDR == FRAME_HDR) begin : g_bad_hdr
        $error("strip_frame_tx: IDLE_HDR must differ from FRAME_HDR");
    end
    if (IDLE_GAP > 15) begin : g_bad_gap
        $error("strip_frame_tx: IDLE_GAP must be in 0..15");
    end

    state_t        state;
    logic [1:0]    idx;
    logic [3:0]    gap_cnt;
    logic [103:0]  shreg;
    logic          accept;
    logic          last_word;
    logic [15:0]   cnt_next;
    logic [103:0]  load_data;

`ifdef STRIP_FRAME_TX_PATTERN_EN
    localparam logic [9:0] PATTERN_TAG = 10'h2A5;
`endif

    always_comb begin
        last_word = (state == S_SEND) && (idx == 2'd3);
        // Count as seen after this edge, so a back-to-back pattern frame gets the next sequence number.
        cnt_next  = last_word ? frame_cnt + 16'd1 : frame_cnt;
`ifdef STRIP_FRAME_TX_PATTERN_EN
        accept    = frame_ready && (test_mode || frame_valid);
        load_data = test_mode ? {4{PATTERN_TAG, cnt_next}} : frame_data;
`else
        accept    = frame_ready && frame_valid;
        load_data = frame_data;
`endif
    end

    assign busy = (state != S_IDLE);

    always_ff @(posedge clk160 or negedge reset_n) begin
        if (!reset_n) begin
            state          <= S_IDLE;
            idx            <= 2'd0;
            gap_cnt        <= 4'd0;
            shreg          <= '0;
            strip_data_out <= IDLE_WORD;
            frame_ready    <= 1'b0;
            frame_cnt      <= 16'd0;
        end else begin
            frame_cnt <= cnt_next;
            case (state)
                S_IDLE: begin
                    strip_data_out <= IDLE_WORD;
                    frame_ready    <= 1'b1;
                end
                S_SEND: begin
                    strip_data_out <= {FRAME_HDR, shreg[103:78]};
                    shreg          <= {shreg[77:0], 26'h0};
                    idx            <= idx + 2'd1;
                    // Ready is raised one cycle early so the next accept lands on the word3 edge.
                    frame_ready    <= (idx == 2'd2) && (IDLE_GAP == 0);
                    if (last_word) begin
                        if (IDLE_GAP == 0) begin
                            state       <= S_IDLE;
                            frame_ready <= 1'b1;
                        end else begin
                            state       <= S_GAP;
                            gap_cnt     <= 4'd0;
                            frame_ready <= (GAP_LAST == 4'd0);
                        end
                    end
                end
                S_GAP: begin
                    strip_data_out <= IDLE_WORD;
                    gap_cnt        <= gap_cnt + 4'd1;
                    frame_ready    <= ((gap_cnt + 4'd1) == GAP_LAST);
                    if (gap_cnt == GAP_LAST) begin
                        state       <= S_IDLE;
                        frame_ready <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
            if (accept) begin
                state       <= S_SEND;
                idx         <= 2'd0;
                shreg       <= load_data;
                frame_ready <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_strip_frame_tx.sv
// Directed bench for strip_frame_tx: one instance with IDLE_GAP=0, one with IDLE_GAP=2.
module tb_strip_frame_tx;

    logic         clk160 = 1'b0;
    logic         reset_n;
    logic [103:0] frame_data, frame_data2;
    logic         frame_valid, frame_valid2;
    logic         frame_ready, frame_ready2;
    logic [29:0]  strip_data_out, strip_data_out2;
    logic         busy, busy2;
    logic [15:0]  frame_cnt, frame_cnt2;
`ifdef STRIP_FRAME_TX_PATTERN_EN
    logic         test_mode;
    logic         test_mode2;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #3 clk160 = ~clk160;

    strip_frame_tx #(.IDLE_GAP(0)) dut (
        .clk160(clk160), .reset_n(reset_n),
`ifdef STRIP_FRAME_TX_PATTERN_EN
        .test_mode(test_mode),
`endif
        .frame_data(frame_data), .frame_valid(frame_valid), .frame_ready(frame_ready),
        .strip_data_out(strip_data_out), .busy(busy), .frame_cnt(frame_cnt)
    );

    strip_frame_tx #(.IDLE_GAP(2)) dut_g2 (
        .clk160(clk160), .reset_n(reset_n),
`ifdef STRIP_FRAME_TX_PATTERN_EN
        .test_mode(test_mode2),
`endif
        .frame_data(frame_data2), .frame_valid(frame_valid2), .frame_ready(frame_ready2),
        .strip_data_out(strip_data_out2), .busy(busy2), .frame_cnt(frame_cnt2)
    );

    function automatic logic [29:0] fw(input logic [103:0] f, input int k);
        return {4'b1010, f[103 - 26*k -: 26]};
    endfunction

    task automatic tick();
        @(posedge clk160);
        #1;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (5) tick();
        n_checks += 4;
        if (strip_data_out !== 30'h0) begin n_fail++; $display("FAIL rst_data got %h want %h", strip_data_out, 30'h0); end
        if (frame_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready got %b want 0", frame_ready); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b want 0", busy); end
        if (frame_cnt !== 16'h0) begin n_fail++; $display("FAIL rst_cnt got %h want 0", frame_cnt); end
        reset_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            n_checks += 4;
            if (strip_data_out !== 30'h0) begin n_fail++; $display("FAIL idle_data c%0d got %h want %h", i, strip_data_out, 30'h0); end
            if (frame_ready !== 1'b1) begin n_fail++; $display("FAIL idle_ready c%0d got %b want 1", i, frame_ready); end
            if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy c%0d got %b want 0", i, busy); end
            if (frame_cnt !== 16'h0) begin n_fail++; $display("FAIL idle_cnt c%0d got %h want 0", i, frame_cnt); end
        end
    endtask

    task automatic test_single_frame();
        logic [103:0] f;
        f = 104'h0123456789ABCDEF0123456789;
        frame_data  = f;
        frame_valid = 1'b1;
        tick();
        frame_valid = 1'b0;
        frame_data  = '0;
        n_checks += 2;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy got %b want 1", busy); end
        if (strip_data_out !== 30'h0) begin n_fail++; $display("FAIL single_lat got %h want %h", strip_data_out, 30'h0); end
        for (int k = 0; k < 4; k++) begin
            tick();
            n_checks++;
            if (strip_data_out !== fw(f, k)) begin n_fail++; $display("FAIL single_w%0d got %h want %h", k, strip_data_out, fw(f, k)); end
        end
        n_checks++;
        if (frame_cnt !== 16'd1) begin n_fail++; $display("FAIL single_cnt got %0d want 1", frame_cnt); end
        tick();
        n_checks += 2;
        if (strip_data_out !== 30'h0) begin n_fail++; $display("FAIL single_idle got %h want %h", strip_data_out, 30'h0); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_end got %b want 0", busy); end
    endtask

    task automatic test_reset_mid_frame();
        logic [103:0] f, h;
        f = 104'hFEDCBA9876543210FEDCBA9876;
        h = 104'h13579BDF02468ACE13579BDF02;
        frame_data  = f;
        frame_valid = 1'b1;
        tick();
        frame_valid = 1'b0;
        tick();
        tick();
        n_checks += 2;
        if (strip_data_out !== fw(f, 1)) begin n_fail++; $display("FAIL mid_w1 got %h want %h", strip_data_out, fw(f, 1)); end
        if (frame_cnt !== 16'd1) begin n_fail++; $display("FAIL mid_cnt_pre got %0d want 1", frame_cnt); end
        #1 reset_n = 1'b0;
        #1;
        n_checks += 4;
        if (strip_data_out !== 30'h0) begin n_fail++; $display("FAIL mid_async_data got %h want %h", strip_data_out, 30'h0); end
        if (frame_cnt !== 16'd0) begin n_fail++; $display("FAIL mid_cnt got %0d want 0", frame_cnt); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy got %b want 0", busy); end
        if (frame_ready !== 1'b0) begin n_fail++; $display("FAIL mid_ready got %b want 0", frame_ready); end
        repeat (3) tick();
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (strip_data_out !== 30'h0) begin n_fail++; $display("FAIL mid_nodrop c%0d got %h want %h", i, strip_data_out, 30'h0); end
        end
        frame_data  = h;
        frame_valid = 1'b1;
        tick();
        frame_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick();
            n_checks++;
            if (strip_data_out !== fw(h, k)) begin n_fail++; $display("FAIL mid_restart_w%0d got %h want %h", k, strip_data_out, fw(h, k)); end
        end
        repeat (3) tick();
    endtask

    task automatic test_back_to_back();
        logic [103:0] fr [3];
        logic         exp_ready;
        fr[0] = 104'h0123456789ABCDEF0123456789;
        fr[1] = 104'hA5A5A5A5A5A5A5A5A5A5A5A5A5;
        fr[2] = 104'h00000000000000000000000001;
        apply_reset();
        frame_data  = fr[0];
        frame_valid = 1'b1;
        tick();
        n_checks++;
        if (frame_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready k0 got %b want 0", frame_ready); end
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k == 1) frame_data = fr[1];
            if (k == 5) frame_data = fr[2];
            if (k == 8) frame_valid = 1'b0;
            exp_ready = ((k % 4) == 3) || (k == 12);
            n_checks += 2;
            if (strip_data_out !== fw(fr[(k-1)/4], (k-1)%4)) begin
                n_fail++;
                $display("FAIL b2b_word k%0d got %h want %h", k, strip_data_out, fw(fr[(k-1)/4], (k-1)%4));
            end
            if (frame_ready !== exp_ready) begin n_fail++; $display("FAIL b2b_ready k%0d got %b want %b", k, frame_ready, exp_ready); end
            if ((k % 4) == 0) begin
                n_checks++;
                if (frame_cnt !== 16'(k/4)) begin n_fail++; $display("FAIL b2b_cnt k%0d got %0d want %0d", k, frame_cnt, k/4); end
            end
        end
        tick();
        n_checks++;
        if (strip_data_out !== 30'h0) begin n_fail++; $display("FAIL b2b_idle got %h want %h", strip_data_out, 30'h0); end
    endtask

    task automatic test_idle_gap();
        logic [103:0] g0, g1;
        logic [29:0]  exp_word;
        logic         exp_ready, exp_busy;
        g0 = 104'h112233445566778899AABBCCDD;
        g1 = 104'hCAFEBABEDEADBEEF0F1E2D3C4B;
        apply_reset();
        frame_data2  = g0;
        frame_valid2 = 1'b1;
        tick();
        frame_data2 = g1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k == 6) frame_valid2 = 1'b0;
            if (k <= 4)       exp_word = fw(g0, k - 1);
            else if (k <= 6)  exp_word = 30'h0;
            else if (k <= 10) exp_word = fw(g1, k - 7);
            else              exp_word = 30'h0;
            exp_ready = (k == 5) || (k >= 11);
            exp_busy  = (k < 12);
            n_checks += 3;
            if (strip_data_out2 !== exp_word) begin n_fail++; $display("FAIL gap_word k%0d got %h want %h", k, strip_data_out2, exp_word); end
            if (frame_ready2 !== exp_ready) begin n_fail++; $display("FAIL gap_ready k%0d got %b want %b", k, frame_ready2, exp_ready); end
            if (busy2 !== exp_busy) begin n_fail++; $display("FAIL gap_busy k%0d got %b want %b", k, busy2, exp_busy); end
        end
        n_checks++;
        if (frame_cnt2 !== 16'd2) begin n_fail++; $display("FAIL gap_cnt got %0d want 2", frame_cnt2); end
    endtask

`ifdef STRIP_FRAME_TX_PATTERN_EN
    task automatic test_pattern();
        logic [29:0] exp_word;
        apply_reset();
        frame_data = 104'hFFFFFFFFFFFFFFFFFFFFFFFFFF;
        test_mode  = 1'b1;
        tick();
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k == 8) test_mode = 1'b0;
            exp_word = {4'b1010, 10'h2A5, 16'((k-1)/4)};
            n_checks++;
            if (strip_data_out !== exp_word) begin n_fail++; $display("FAIL pat_word k%0d got %h want %h", k, strip_data_out, exp_word); end
        end
        tick();
        n_checks += 2;
        if (strip_data_out !== 30'h0) begin n_fail++; $display("FAIL pat_idle got %h want %h", strip_data_out, 30'h0); end
        if (frame_cnt !== 16'd3) begin n_fail++; $display("FAIL pat_cnt got %0d want 3", frame_cnt); end
    endtask
`endif

    initial begin
        reset_n      = 1'b0;
        frame_data   = '0;
        frame_valid  = 1'b0;
        frame_data2  = '0;
        frame_valid2 = 1'b0;
`ifdef STRIP_FRAME_TX_PATTERN_EN
        test_mode    = 1'b0;
        test_mode2   = 1'b0;
`endif
        test_reset();
        test_single_frame();
        test_reset_mid_frame();
        test_back_to_back();
        test_idle_gap();
`ifdef STRIP_FRAME_TX_PATTERN_EN
        test_pattern();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
